// File: rtl/key_debounce_pulse_pkg.sv
// Shared definitions for push-button input blocks: FSM state encoding and
// default timing constants for 50 MHz boards.
package key_debounce_pulse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PRESS_CHK = 2'd1,
        ST_HELD      = 2'd2,
        ST_REL_CHK   = 2'd3
    } key_state_t;

    localparam int CLK_HZ          = 50_000_000;
    localparam int DEF_DEB_CYCLES  = 1_000_000;   // 20 ms
    localparam int DEF_CNT_W       = 20;
    localparam int DEF_REP_DELAY   = 25_000_000;  // 500 ms
    localparam int DEF_REP_PERIOD  = 5_000_000;   // 100 ms

    // Bits needed to hold values 0..n
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/key_debounce_pulse_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit; async active-high reset
// loads RST_VAL into both stages.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic CLK,
    input  logic RST,
    input  logic D,
    output logic Q
);

    logic meta_p0;
    logic sync_p1;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            meta_p0 <= RST_VAL;
            sync_p1 <= RST_VAL;
        end else begin
            meta_p0 <= D;
            sync_p1 <= meta_p0;
        end
    end

    assign Q = sync_p1;

endmodule

// File: rtl/key_debounce_pulse.sv
// Push-button debouncer producing one count-enable pulse per accepted press,
// a release pulse and the debounced level. Auto-repeat under `KEY_REPEAT_EN.
module key_debounce_pulse
    import key_debounce_pulse_pkg::*;
#(
    parameter int DEB_CYCLES  = DEF_DEB_CYCLES,
    parameter int CNT_W       = DEF_CNT_W,
    parameter bit KEY_ACT_LOW = 1'b1,
    parameter int REP_DELAY   = DEF_REP_DELAY,
    parameter int REP_PERIOD  = DEF_REP_PERIOD
) (
    input  logic CLK,
    input  logic RST,
    input  logic KEY_IN,
    output logic KEY_LEVEL,
    output logic KEY_PULSE,
    output logic KEY_REL
);

    if (DEB_CYCLES < 2 || (2 ** CNT_W) <= DEB_CYCLES || REP_PERIOD < 1 || REP_DELAY < 1) begin : g_bad_cfg
        $error("key_debounce_pulse: illegal timing parameters");
    end

    // Transition fires on the cycle the counter would step to DEB_CYCLES-1,
    // which keeps edge-to-pulse latency at exactly 2 + DEB_CYCLES clocks.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 2);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    logic             key_sync;
    logic             k;
    key_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;
    logic             rel_q, rel_d;
    logic             level_q, level_d;
    logic             rep_fire;

    sync_2ff #(
        .RST_VAL (KEY_ACT_LOW)
    ) u_sync (
        .CLK (CLK),
        .RST (RST),
        .D   (KEY_IN),
        .Q   (key_sync)
    );

    assign k = KEY_ACT_LOW ? ~key_sync : key_sync;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (k) state_d = ST_PRESS_CHK;
            ST_PRESS_CHK: if (!k) state_d = ST_IDLE;
                          else if (cnt_q == CNT_LAST) state_d = ST_HELD;
            ST_HELD:      if (!k) state_d = ST_REL_CHK;
            ST_REL_CHK:   if (k) state_d = ST_HELD;
                          else if (cnt_q == CNT_LAST) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = '0;
        pulse_d = 1'b0;
        rel_d   = 1'b0;
        level_d = (state_q == ST_HELD) || (state_q == ST_REL_CHK);
        if (state_d == state_q && (state_q == ST_PRESS_CHK || state_q == ST_REL_CHK))
            cnt_d = sat_inc(cnt_q);
        if (state_q == ST_PRESS_CHK && state_d == ST_HELD)
            pulse_d = 1'b1;
        if (state_q == ST_REL_CHK && state_d == ST_IDLE)
            rel_d = 1'b1;
        if (rep_fire)
            pulse_d = 1'b1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            rel_q   <= 1'b0;
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            rel_q   <= rel_d;
            level_q <= level_d;
        end
    end

`ifdef KEY_REPEAT_EN
    localparam int REP_W = cnt_width((REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD);
    localparam logic [REP_W-1:0] REP_DELAY_LAST  = REP_W'(REP_DELAY - 1);
    localparam logic [REP_W-1:0] REP_PERIOD_LAST = REP_W'(REP_PERIOD - 1);

    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             rep_first_q, rep_first_d;
    logic             rep_fire_d;

    // Any cycle not spent staying in HELD re-arms the initial delay.
    always_comb begin
        rep_cnt_d   = rep_cnt_q;
        rep_first_d = rep_first_q;
        rep_fire_d  = 1'b0;
        if (state_q != ST_HELD || state_d != ST_HELD) begin
            rep_cnt_d   = '0;
            rep_first_d = 1'b1;
        end else if (rep_cnt_q == (rep_first_q ? REP_DELAY_LAST : REP_PERIOD_LAST)) begin
            rep_fire_d  = 1'b1;
            rep_cnt_d   = '0;
            rep_first_d = 1'b0;
        end else begin
            rep_cnt_d   = rep_cnt_q + REP_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rep_cnt_q   <= '0;
            rep_first_q <= 1'b1;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_first_q <= rep_first_d;
        end
    end

    assign rep_fire = rep_fire_d;
`else
    assign rep_fire = 1'b0;
`endif

    assign KEY_LEVEL = level_q;
    assign KEY_PULSE = pulse_q;
    assign KEY_REL   = rel_q;

endmodule

// File: tb/tb_key_debounce_pulse.sv
// Scoreboard bench for key_debounce_pulse: expected press/release events are
// queued with their due cycle as KEY_IN is driven and matched as they appear.
`timescale 1ns/1ps
module tb_key_debounce_pulse;

    localparam int DEB   = 8;
    localparam int LAT   = DEB + 2;
    localparam int REP_D = 20;
    localparam int REP_P = 6;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic KEY_IN = 1'b1;
    logic KEY_LEVEL, KEY_PULSE, KEY_REL;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int press_count = 0;

    typedef struct {
        int kind;   // 1 = press pulse, 2 = release pulse
        int at;
    } ev_t;
    ev_t sb[$];

    key_debounce_pulse #(
        .DEB_CYCLES  (DEB),
        .CNT_W       (4),
        .KEY_ACT_LOW (1'b1),
        .REP_DELAY   (REP_D),
        .REP_PERIOD  (REP_P)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .KEY_IN    (KEY_IN),
        .KEY_LEVEL (KEY_LEVEL),
        .KEY_PULSE (KEY_PULSE),
        .KEY_REL   (KEY_REL)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic expect_ev(input int kind, input int at);
        ev_t e;
        e.kind = kind;
        e.at   = at;
        sb.push_back(e);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_level"}, KEY_LEVEL, 0);
        check({tag, "_pulse"}, KEY_PULSE, 0);
        check({tag, "_rel"},   KEY_REL,   0);
    endtask

    always @(negedge CLK) begin
        ev_t e;
        if (KEY_PULSE !== 1'b0 || KEY_REL !== 1'b0) begin
            check("no_overlap", KEY_PULSE & KEY_REL, 0);
            check("sb_has_entry", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("ev_kind", KEY_PULSE ? 1 : 2, e.kind);
                check("ev_cycle", cyc, e.at);
            end
            if (KEY_PULSE === 1'b1) press_count++;
        end
    end

    initial begin
        int e0, s0, r0, pc0, a0;

        // reset held with key released
        tick(1);
        check_idle_outputs("rst_a");
        tick(2);
        check_idle_outputs("rst_b");
        RST = 1'b0;
        tick(5);

        // clean press held 30 cycles
        e0 = cyc;
        KEY_IN = 1'b0;
        expect_ev(1, e0 + LAT);
`ifdef KEY_REPEAT_EN
        expect_ev(1, e0 + LAT + REP_D);
`endif
        tick(LAT);
        check("t2_level_at_pulse", KEY_LEVEL, 0);
        tick(1);
        check("t2_level_after", KEY_LEVEL, 1);
        tick(30 - LAT - 1);
        KEY_IN = 1'b1;
        expect_ev(2, cyc + LAT);
        tick(LAT);
        check("t2_level_at_rel", KEY_LEVEL, 1);
        tick(1);
        check("t2_level_released", KEY_LEVEL, 0);
        tick(5);
        check("t2_drained", sb.size(), 0);

        // bounce shorter than the debounce window
        pc0 = press_count;
        for (int i = 0; i < 40; i++) begin
            KEY_IN = ((i / 3) % 2 == 0) ? 1'b0 : 1'b1;
            tick(1);
            if (i % 10 == 9) check("t3_level", KEY_LEVEL, 0);
        end
        KEY_IN = 1'b1;
        tick(15);
        check("t3_level_end", KEY_LEVEL, 0);
        check("t3_no_press", press_count - pc0, 0);
        check("t3_drained", sb.size(), 0);

        // release with a 4-cycle glitch back to pressed
        e0 = cyc;
        KEY_IN = 1'b0;
        expect_ev(1, e0 + LAT);
        tick(14);
        s0 = cyc;
        KEY_IN = 1'b1;
        tick(5);
        KEY_IN = 1'b0;
        tick(4);
        KEY_IN = 1'b1;
        expect_ev(2, s0 + 9 + LAT);
        tick(9);
        check("t4_level_hold", KEY_LEVEL, 1);
        tick(2);
        check("t4_level_rel", KEY_LEVEL, 0);
        tick(5);
        check("t4_drained", sb.size(), 0);

        // reset pulsed in the middle of a held press
        pc0 = press_count;
        e0 = cyc;
        KEY_IN = 1'b0;
        expect_ev(1, e0 + LAT);
        tick(15);
        check("t5_level_pre", KEY_LEVEL, 1);
        RST = 1'b1;
        #1;
        check_idle_outputs("t5_rst_async");
        tick(1);
        check_idle_outputs("t5_rst_hold");
        tick(1);
        RST = 1'b0;
        r0 = cyc;
        expect_ev(1, r0 + LAT);
        tick(LAT);
        check("t5_level_at_pulse", KEY_LEVEL, 0);
        tick(1);
        check("t5_level_after", KEY_LEVEL, 1);
        check("t5_count", press_count - pc0, 2);
        KEY_IN = 1'b1;
        expect_ev(2, cyc + LAT);
        tick(LAT + 5);
        check("t5_drained", sb.size(), 0);

        // long hold: repeats only when the feature is built in
        pc0 = press_count;
        e0 = cyc;
        a0 = e0 + LAT;
        KEY_IN = 1'b0;
        expect_ev(1, a0);
`ifdef KEY_REPEAT_EN
        for (int j = 0; j < 5; j++) expect_ev(1, a0 + REP_D + j * REP_P);
`endif
        tick(LAT + 44);
        KEY_IN = 1'b1;
        expect_ev(2, cyc + LAT);
        tick(LAT + 10);
`ifdef KEY_REPEAT_EN
        check("t6_count", press_count - pc0, 6);
`else
        check("t6_count", press_count - pc0, 1);
`endif
        check("t6_level_end", KEY_LEVEL, 0);
        check("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
